// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of the two requester ports, the two response ports,
// the shared-ALU drive/return signals and status for alu_arbiter.
//
// Handshake rule (all channels): a transfer happens on a rising clock edge
// where both valid and ready are high. A source may drop valid at any time
// before that edge without effect. While valid is high and the transfer has
// not happened, the payload it qualifies is held stable by its source.
interface alu_arbiter_if #(
    parameter int TAG_W = 4
);
    // Requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_sel;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic [4:0]       req0_shamt;
    logic [TAG_W-1:0] req0_tag;
    // Requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_sel;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic [4:0]       req1_shamt;
    logic [TAG_W-1:0] req1_tag;
    // Responses
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [31:0]      rsp0_data;
    logic [TAG_W-1:0] rsp0_tag;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [31:0]      rsp1_data;
    logic [TAG_W-1:0] rsp1_tag;
    // Shared ALU
    logic [3:0]       alu_sel;
    logic [31:0]      alu_data_1;
    logic [31:0]      alu_data_2;
    logic [4:0]       alu_shamt;
    logic [31:0]      alu_out;
    // Status and FSM state visibility (0 IDLE, 1 EXEC, 2 RESP)
    logic             busy;
    logic [1:0]       dbg_state;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b, req0_shamt, req0_tag,
        input  req1_valid, req1_sel, req1_a, req1_b, req1_shamt, req1_tag,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_tag,
        output rsp1_valid, rsp1_data, rsp1_tag,
        input  rsp0_ready, rsp1_ready,
        output alu_sel, alu_data_1, alu_data_2, alu_shamt,
        input  alu_out,
        output busy, dbg_state
    );

    // Requester / ALU side
    modport master (
        output req0_valid, req0_sel, req0_a, req0_b, req0_shamt, req0_tag,
        output req1_valid, req1_sel, req1_a, req1_b, req1_shamt, req1_tag,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_tag,
        input  rsp1_valid, rsp1_data, rsp1_tag,
        output rsp0_ready, rsp1_ready,
        input  alu_sel, alu_data_1, alu_data_2, alu_shamt,
        output alu_out,
        input  busy, dbg_state
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Flow per operation: IDLE (accept) -> EXEC (drive ALU, capture result)
// -> RESP (hold result until the owner consumes it) -> IDLE.
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN -- when defined, contention
// alternates between requesters using a last-grant pointer; when undefined,
// requester 0 always wins and no pointer exists.
module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SEL_NOP = 4'b1111;

    state_t           r_state;
    logic             r_gnt;        // index of the requester being served
    logic [3:0]       r_alu_sel;
    logic [31:0]      r_alu_data_1;
    logic [31:0]      r_alu_data_2;
    logic [4:0]       r_alu_shamt;
    logic [TAG_W-1:0] r_tag;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [31:0]      r_rsp_data;
    logic [TAG_W-1:0] r_rsp_tag;

    logic             w_any;
    logic             w_gnt;
    logic             w_accept;
    logic             w_rsp_done;
    logic [3:0]       w_sel;
    logic [31:0]      w_a;
    logic [31:0]      w_b;
    logic [4:0]       w_shamt;
    logic [TAG_W-1:0] w_tag;

    assign w_any = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic r_last;   // requester granted most recently

    // Winner selection: on contention the requester that did not win last time
    always_comb begin
        w_gnt = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt = ~r_last;
        end else if (bus.req1_valid) begin
            w_gnt = 1'b1;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is not asking
    assign w_gnt = ~bus.req0_valid & bus.req1_valid;
`endif

    // Acceptance is only possible in IDLE; reset gating keeps ready low in reset
    assign w_accept = rst_n && (r_state == IDLE) && w_any;
    assign bus.req0_ready = w_accept & ~w_gnt;
    assign bus.req1_ready = w_accept &  w_gnt;

    assign w_sel   = w_gnt ? bus.req1_sel   : bus.req0_sel;
    assign w_a     = w_gnt ? bus.req1_a     : bus.req0_a;
    assign w_b     = w_gnt ? bus.req1_b     : bus.req0_b;
    assign w_shamt = w_gnt ? bus.req1_shamt : bus.req0_shamt;
    assign w_tag   = w_gnt ? bus.req1_tag   : bus.req0_tag;

    assign w_rsp_done = (r_rsp0_valid & bus.rsp0_ready) |
                        (r_rsp1_valid & bus.rsp1_ready);

    // Arbitration FSM; ALU drive and response outputs are all registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_gnt        <= 1'b0;
            r_alu_sel    <= SEL_NOP;
            r_alu_data_1 <= '0;
            r_alu_data_2 <= '0;
            r_alu_shamt  <= '0;
            r_tag        <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_tag    <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            r_last       <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // Operands go straight onto the ALU for the EXEC cycle
                        r_gnt        <= w_gnt;
                        r_alu_sel    <= w_sel;
                        r_alu_data_1 <= w_a;
                        r_alu_data_2 <= w_b;
                        r_alu_shamt  <= w_shamt;
                        r_tag        <= w_tag;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        r_last       <= w_gnt;
`endif
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data   <= bus.alu_out;
                    r_rsp_tag    <= r_tag;
                    r_rsp0_valid <= ~r_gnt;
                    r_rsp1_valid <=  r_gnt;
                    r_alu_sel    <= SEL_NOP;
                    r_alu_data_1 <= '0;
                    r_alu_data_2 <= '0;
                    r_alu_shamt  <= '0;
                    r_state      <= RESP;
                end
                RESP: begin
                    // Completion cycle never overlaps a new acceptance
                    if (w_rsp_done) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_data  = r_rsp_data;
    assign bus.rsp1_data  = r_rsp_data;
    assign bus.rsp0_tag   = r_rsp_tag;
    assign bus.rsp1_tag   = r_rsp_tag;
    assign bus.alu_sel    = r_alu_sel;
    assign bus.alu_data_1 = r_alu_data_1;
    assign bus.alu_data_2 = r_alu_data_2;
    assign bus.alu_shamt  = r_alu_shamt;
    assign bus.busy       = (r_state != IDLE);
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small shared-ALU model.
// ALU codes used here: 0 ADD (a+b), 1 SUB (a-b), 7 SRA (b >>> shamt).
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SRA = 4'd7;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.TAG_W(4)) bus ();

    alu_arbiter #(.TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared ALU model
    always_comb begin
        bus.alu_out = 32'h0;
        case (bus.alu_sel)
            OP_ADD:  bus.alu_out = bus.alu_data_1 + bus.alu_data_2;
            OP_SUB:  bus.alu_out = bus.alu_data_1 - bus.alu_data_2;
            OP_SRA:  bus.alu_out = $unsigned($signed(bus.alu_data_2) >>> bus.alu_shamt);
            default: bus.alu_out = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 1'b0; bus.req0_sel = 4'h0; bus.req0_a = '0;
        bus.req0_b = '0; bus.req0_shamt = '0; bus.req0_tag = '0;
        bus.req1_valid = 1'b0; bus.req1_sel = 4'h0; bus.req1_a = '0;
        bus.req1_b = '0; bus.req1_shamt = '0; bus.req1_tag = '0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic drive_req(input int n, input logic [3:0] sel, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] sh, input logic [3:0] tag);
        if (n == 0) begin
            bus.req0_valid = 1'b1; bus.req0_sel = sel; bus.req0_a = a;
            bus.req0_b = b; bus.req0_shamt = sh; bus.req0_tag = tag;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_sel = sel; bus.req1_a = a;
            bus.req1_b = b; bus.req1_shamt = sh; bus.req1_tag = tag;
        end
    endtask

    initial begin
        int g;
        // ---- reset: ready stays low even with a valid request present
        rst_n = 1'b0;
        clear_inputs();
        bus.req0_valid = 1'b1;
        step();
        #1;
        check("rst_ready0", bus.req0_ready, 1'b0);
        check("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_alu_sel", bus.alu_sel, 4'hF);
        step();
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rst_rsp0_data", bus.rsp0_data, 32'h0);
        check("rst_rsp0_tag", bus.rsp0_tag, 4'h0);
        check("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        check("rst_alu_d1", bus.alu_data_1, 32'h0);
        check("rst_alu_shamt", bus.alu_shamt, 5'h0);

        // ---- idle with no requests
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            check("idle_alu_sel", bus.alu_sel, 4'hF);
            check("idle_alu_d1", bus.alu_data_1, 32'h0);
            check("idle_alu_d2", bus.alu_data_2, 32'h0);
            check("idle_ready0", bus.req0_ready, 1'b0);
            check("idle_ready1", bus.req1_ready, 1'b0);
            check("idle_rsp0_valid", bus.rsp0_valid, 1'b0);
            check("idle_rsp1_valid", bus.rsp1_valid, 1'b0);
        end

        // ---- req0 ADD 5+7 tag 3, consumer always ready
        drive_req(0, OP_ADD, 32'd5, 32'd7, 5'd0, 4'd3);
        bus.rsp0_ready = 1'b1;
        #1;
        check("add_ready0", bus.req0_ready, 1'b1);
        check("add_ready1", bus.req1_ready, 1'b0);
        step();
        bus.req0_valid = 1'b0;
        #1;
        check("add_exec_busy", bus.busy, 1'b1);
        check("add_exec_sel", bus.alu_sel, OP_ADD);
        check("add_exec_d1", bus.alu_data_1, 32'd5);
        check("add_exec_d2", bus.alu_data_2, 32'd7);
        check("add_exec_ready0", bus.req0_ready, 1'b0);
        check("add_exec_rsp0_valid", bus.rsp0_valid, 1'b0);
        step();
        #1;
        check("add_rsp0_valid", bus.rsp0_valid, 1'b1);
        check("add_rsp0_data", bus.rsp0_data, 32'd12);
        check("add_rsp0_tag", bus.rsp0_tag, 4'd3);
        check("add_rsp1_valid", bus.rsp1_valid, 1'b0);
        check("add_resp_alu_sel", bus.alu_sel, 4'hF);
        step();
        #1;
        check("add_done_rsp0_valid", bus.rsp0_valid, 1'b0);
        check("add_done_busy", bus.busy, 1'b0);
        bus.rsp0_ready = 1'b0;

        // ---- req1 SRA 0x80000000 >>> 4, consumer stalls 5 cycles
        drive_req(1, OP_SRA, 32'h0, 32'h8000_0000, 5'd4, 4'd5);
        #1;
        check("sra_ready1", bus.req1_ready, 1'b1);
        check("sra_ready0", bus.req0_ready, 1'b0);
        step();
        bus.req1_valid = 1'b0;
        #1;
        check("sra_exec_sel", bus.alu_sel, OP_SRA);
        check("sra_exec_shamt", bus.alu_shamt, 5'd4);
        check("sra_exec_d2", bus.alu_data_2, 32'h8000_0000);
        step();
        drive_req(0, OP_ADD, 32'd1, 32'd1, 5'd0, 4'd0);
        drive_req(1, OP_ADD, 32'd2, 32'd2, 5'd0, 4'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("sra_hold_rsp1_valid", bus.rsp1_valid, 1'b1);
            check("sra_hold_rsp1_data", bus.rsp1_data, 32'hF800_0000);
            check("sra_hold_rsp1_tag", bus.rsp1_tag, 4'd5);
            check("sra_hold_rsp0_valid", bus.rsp0_valid, 1'b0);
            check("sra_hold_ready0", bus.req0_ready, 1'b0);
            check("sra_hold_ready1", bus.req1_ready, 1'b0);
            check("sra_hold_busy", bus.busy, 1'b1);
            if (i < 4) step();
        end
        // completion cycle must not accept the waiting req0
        bus.req1_valid = 1'b0;
        bus.rsp1_ready = 1'b1;
        #1;
        check("sra_done_ready0", bus.req0_ready, 1'b0);
        check("sra_done_rsp1_valid", bus.rsp1_valid, 1'b1);
        step();
        #1;
        check("sra_idle_rsp1_valid", bus.rsp1_valid, 1'b0);
        check("sra_idle_busy", bus.busy, 1'b0);
        check("sra_idle_ready0", bus.req0_ready, 1'b1);
        // withdraw without a handshake
        bus.req0_valid = 1'b0;
        bus.rsp1_ready = 1'b0;
        #1;
        check("withdraw_ready0", bus.req0_ready, 1'b0);
        step();
        #1;
        check("withdraw_busy", bus.busy, 1'b0);

        // ---- contention: both requesters valid continuously, SUB ops
        drive_req(0, OP_SUB, 32'd100, 32'd1, 5'd0, 4'd0);
        drive_req(1, OP_SUB, 32'd50, 32'd8, 5'd0, 4'd1);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            g = k % 2;
`else
            g = 0;
`endif
            #1;
            check("cont_ready0", bus.req0_ready, 1'(g == 0));
            check("cont_ready1", bus.req1_ready, 1'(g == 1));
            step();
            step();
            #1;
            check("cont_rsp0_valid", bus.rsp0_valid, 1'(g == 0));
            check("cont_rsp1_valid", bus.rsp1_valid, 1'(g == 1));
            check("cont_data", (g == 1) ? bus.rsp1_data : bus.rsp0_data,
                  (g == 1) ? 32'd42 : 32'd99);
            check("cont_tag", (g == 1) ? bus.rsp1_tag : bus.rsp0_tag, 4'(g));
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // ---- reset in the middle of EXEC
        drive_req(0, OP_ADD, 32'd2, 32'd3, 5'd0, 4'd6);
        #1;
        check("rstx_ready0", bus.req0_ready, 1'b1);
        step();
        bus.req0_valid = 1'b0;
        #1;
        check("rstx_exec_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("rstx_busy", bus.busy, 1'b0);
        check("rstx_rsp0_valid", bus.rsp0_valid, 1'b0);
        check("rstx_rsp1_valid", bus.rsp1_valid, 1'b0);
        check("rstx_alu_sel", bus.alu_sel, 4'hF);
        check("rstx_rsp0_data", bus.rsp0_data, 32'h0);
        step();
        #1;
        check("rstx_after_rsp0_valid", bus.rsp0_valid, 1'b0);
        check("rstx_after_busy", bus.busy, 1'b0);

        // ---- first contention after reset goes to requester 0 in both builds
        drive_req(0, OP_ADD, 32'd1, 32'd1, 5'd0, 4'd0);
        drive_req(1, OP_ADD, 32'd1, 32'd1, 5'd0, 4'd1);
        #1;
        check("post_rst_ready0", bus.req0_ready, 1'b1);
        check("post_rst_ready1", bus.req1_ready, 1'b0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
